// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer: state encoding,
// BCD digit width, digit limits and a digit clamp helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    // Saturate a single BCD digit to an upper limit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] d,
        input logic [DIGIT_W-1:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the user-input stage, the timer and its
// consumers (display driver, alarm logic). master drives commands, slave is
// the timer itself.
interface bcd_countdown_timer_if;
    logic       tick;
    logic       start;
    logic       pause;
    logic       clear;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output tick, start, pause, clear, load, load_min, load_sec,
        input  min_bcd, sec_bcd, running, done, expired
    );

    modport slave (
        input  tick, start, pause, clear, load, load_min, load_sec,
        output min_bcd, sec_bcd, running, done, expired
    );
endinterface

// File: rtl/bcd_countdown_timer_bcd_digit_dec.sv
// One BCD digit of a ripple-borrow decrementer. A borrow into a zero digit
// wraps it to limit_i and propagates the borrow to the next digit.
module bcd_digit_dec
    import timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic [DIGIT_W-1:0] limit_i,
    input  logic               borrow_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               borrow_o
);

    // Decrement only when a borrow arrives; zero wraps to the digit limit.
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == '0) begin
                digit_o  = limit_i;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer driven by an external periodic tick.
// Optional build macro: TIMER_AUTORELOAD_EN (reload last loaded value on
// reaching 00:00 instead of stopping).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | stopped; count is whatever was loaded or cleared
// RUN     | counting down one second per tick event
// PAUSE   | stopped mid-count, resumable with start
// EXPIRED | reached 00:00; expired held until clear or load
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] MAX_MIN_BCD = 8'h99
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_countdown_timer_if.slave tmr
);

    state_e     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       expired_q, expired_d;
    logic       tick_q;
    logic       tick_evt;

    logic [7:0] ld_min, ld_sec;
    logic [7:0] dec_min, dec_sec;
    logic       b_so, b_st, b_mo, b_mt;
    logic       count_zero, dec_zero;

    assign tick_evt = tmr.tick & ~tick_q;

    // Out-of-range minutes are judged on the raw value first, so a non-BCD
    // entry like A7 saturates to the full limit rather than to 97.
    assign ld_min = (tmr.load_min > MAX_MIN_BCD) ? MAX_MIN_BCD :
                    {clamp_digit(tmr.load_min[7:4], DIGIT_MAX),
                     clamp_digit(tmr.load_min[3:0], DIGIT_MAX)};
    assign ld_sec = {clamp_digit(tmr.load_sec[7:4], SEC_TENS_MAX),
                     clamp_digit(tmr.load_sec[3:0], DIGIT_MAX)};

    bcd_digit_dec u_sec_ones (
        .digit_i (sec_q[3:0]), .limit_i (DIGIT_MAX),    .borrow_i (1'b1),
        .digit_o (dec_sec[3:0]), .borrow_o (b_so));
    bcd_digit_dec u_sec_tens (
        .digit_i (sec_q[7:4]), .limit_i (SEC_TENS_MAX), .borrow_i (b_so),
        .digit_o (dec_sec[7:4]), .borrow_o (b_st));
    bcd_digit_dec u_min_ones (
        .digit_i (min_q[3:0]), .limit_i (DIGIT_MAX),    .borrow_i (b_st),
        .digit_o (dec_min[3:0]), .borrow_o (b_mo));
    bcd_digit_dec u_min_tens (
        .digit_i (min_q[7:4]), .limit_i (DIGIT_MAX),    .borrow_i (b_mo),
        .digit_o (dec_min[7:4]), .borrow_o (b_mt));

    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign dec_zero   = (dec_min == 8'h00) && (dec_sec == 8'h00);

`ifdef TIMER_AUTORELOAD_EN
    logic [7:0] rld_min_q, rld_min_d;
    logic [7:0] rld_sec_q, rld_sec_d;

    // Reload register holds the last post-clamp loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rld_min_q <= 8'h00;
            rld_sec_q <= 8'h00;
        end else begin
            rld_min_q <= rld_min_d;
            rld_sec_q <= rld_sec_d;
        end
    end
`endif

    // Next-state and registered-output logic; commands in priority order.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        rld_min_d = rld_min_q;
        rld_sec_d = rld_sec_q;
`endif
        if (tmr.clear) begin
            state_d = IDLE;
            min_d   = 8'h00;
            sec_d   = 8'h00;
        end else if (tmr.load && (state_q != RUN)) begin
            state_d = IDLE;
            min_d   = ld_min;
            sec_d   = ld_sec;
`ifdef TIMER_AUTORELOAD_EN
            rld_min_d = ld_min;
            rld_sec_d = ld_sec;
`endif
        end else if (tmr.pause && (state_q == RUN)) begin
            state_d = PAUSE;
        end else if (tmr.start && ((state_q == IDLE) || (state_q == PAUSE))) begin
            if (!count_zero) begin
                state_d = RUN;
            end
        end else if (tick_evt && (state_q == RUN) && !b_mt) begin
            // b_mt would only be set when decrementing 00:00; never wrap.
            min_d = dec_min;
            sec_d = dec_sec;
            if (dec_zero) begin
                done_d  = 1'b1;
                state_d = EXPIRED;
`ifdef TIMER_AUTORELOAD_EN
                // A zero reload value falls back to stopping at 00:00.
                if ((rld_min_q != 8'h00) || (rld_sec_q != 8'h00)) begin
                    state_d = RUN;
                    min_d   = rld_min_q;
                    sec_d   = rld_sec_q;
                end
`endif
            end
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    // State, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            done_q    <= done_d;
            expired_q <= expired_d;
            tick_q    <= tmr.tick;
        end
    end

    assign tmr.min_bcd = min_q;
    assign tmr.sec_bcd = sec_q;
    assign tmr.running = running_q;
    assign tmr.done    = done_q;
    assign tmr.expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: a vector table for the single-cycle
// command behaviour, plus hand sequences for expiry, held tick, reset and the
// reduced minute limit.
module tb_bcd_countdown_timer;

    typedef struct {
        logic       st, pa, cl, ld, tk;
        logic [7:0] lmin, lsec;
        logic [7:0] emin, esec;
        logic       er, ed, ee;
    } vec_t;

    localparam int NV = 24;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NV];

    bcd_countdown_timer_if tif ();
    bcd_countdown_timer_if tif2 ();

    bcd_countdown_timer #(.MAX_MIN_BCD(8'h99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (tif)
    );

    bcd_countdown_timer #(.MAX_MIN_BCD(8'h30)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .tmr   (tif2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic st, input logic pa, input logic cl, input logic ld,
        input logic tk, input logic [7:0] lmin, input logic [7:0] lsec,
        input logic [7:0] emin, input logic [7:0] esec,
        input logic er, input logic ed, input logic ee);
        vec_t v;
        v.st = st; v.pa = pa; v.cl = cl; v.ld = ld; v.tk = tk;
        v.lmin = lmin; v.lsec = lsec;
        v.emin = emin; v.esec = esec;
        v.er = er; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got mm:ss/run/done/exp=%h:%h/%b/%b/%b required %h:%h/%b/%b/%b",
                     name, act[18:11], act[10:3], act[2], act[1], act[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] m, input logic [7:0] s,
                           input logic r, input logic d, input logic e);
        chk(name, {tif.min_bcd, tif.sec_bcd, tif.running, tif.done, tif.expired},
            {m, s, r, d, e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic pa, input logic cl, input logic ld,
                         input logic tk, input logic [7:0] lmin, input logic [7:0] lsec);
        tif.start = st; tif.pause = pa; tif.clear = cl; tif.load = ld; tif.tick = tk;
        tif.load_min = lmin; tif.load_sec = lsec;
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = mk(0,0,0,1,0, 8'h01,8'h00, 8'h01,8'h00, 0,0,0);
        vecs[1]  = mk(1,0,0,0,0, 8'h00,8'h00, 8'h01,8'h00, 1,0,0);
        vecs[2]  = mk(0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h59, 1,0,0);
        vecs[3]  = mk(0,0,0,0,0, 8'h00,8'h00, 8'h00,8'h59, 1,0,0);
        vecs[4]  = mk(0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);
        vecs[5]  = mk(0,0,0,1,0, 8'h10,8'h00, 8'h10,8'h00, 0,0,0);
        vecs[6]  = mk(1,0,0,0,0, 8'h00,8'h00, 8'h10,8'h00, 1,0,0);
        vecs[7]  = mk(0,0,0,0,1, 8'h00,8'h00, 8'h09,8'h59, 1,0,0);
        vecs[8]  = mk(0,0,0,0,0, 8'h00,8'h00, 8'h09,8'h59, 1,0,0);
        vecs[9]  = mk(0,0,0,1,0, 8'hA7,8'h7C, 8'h09,8'h59, 1,0,0);
        vecs[10] = mk(0,0,1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);
        vecs[11] = mk(0,0,0,1,0, 8'hA7,8'h7C, 8'h99,8'h59, 0,0,0);
        vecs[12] = mk(0,0,0,1,0, 8'h2F,8'h3A, 8'h29,8'h39, 0,0,0);
        vecs[13] = mk(0,0,0,1,0, 8'h00,8'h05, 8'h00,8'h05, 0,0,0);
        vecs[14] = mk(1,0,0,0,0, 8'h00,8'h00, 8'h00,8'h05, 1,0,0);
        vecs[15] = mk(0,1,0,0,1, 8'h00,8'h00, 8'h00,8'h05, 0,0,0);
        vecs[16] = mk(1,0,0,0,0, 8'h00,8'h00, 8'h00,8'h05, 1,0,0);
        vecs[17] = mk(0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h04, 1,0,0);
        vecs[18] = mk(0,1,0,0,0, 8'h00,8'h00, 8'h00,8'h04, 0,0,0);
        vecs[19] = mk(0,0,0,1,0, 8'h00,8'h30, 8'h00,8'h30, 0,0,0);
        vecs[20] = mk(0,0,1,1,0, 8'h12,8'h34, 8'h00,8'h00, 0,0,0);
        vecs[21] = mk(1,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);
        vecs[22] = mk(0,0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);
        vecs[23] = mk(0,0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0);

        drive(0,0,0,0,0, 8'h00, 8'h00);
        tif2.start = 1'b0; tif2.pause = 1'b0; tif2.clear = 1'b0; tif2.load = 1'b0;
        tif2.tick = 1'b0; tif2.load_min = 8'h00; tif2.load_sec = 8'h00;
        rst_n = 1'b0;
        #1;
        chk_out("reset", 8'h00, 8'h00, 0, 0, 0);
        #12;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].st, vecs[i].pa, vecs[i].cl, vecs[i].ld, vecs[i].tk,
                  vecs[i].lmin, vecs[i].lsec);
            cyc();
            chk_out($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec,
                    vecs[i].er, vecs[i].ed, vecs[i].ee);
        end
        drive(0,0,0,0,0, 8'h00, 8'h00);

        // Expiry from 00:02.
        drive(0,0,0,1,0, 8'h00, 8'h02); cyc();
        drive(1,0,0,0,0, 8'h00, 8'h00); cyc();
        drive(0,0,0,0,1, 8'h00, 8'h00); cyc();
        chk_out("exp_first_tick", 8'h00, 8'h01, 1, 0, 0);
        drive(0,0,0,0,0, 8'h00, 8'h00); cyc();
        drive(0,0,0,0,1, 8'h00, 8'h00); cyc();
`ifdef TIMER_AUTORELOAD_EN
        chk_out("exp_reach_zero", 8'h00, 8'h02, 1, 1, 0);
        drive(0,0,0,0,0, 8'h00, 8'h00); cyc();
        chk_out("exp_after", 8'h00, 8'h02, 1, 0, 0);
`else
        chk_out("exp_reach_zero", 8'h00, 8'h00, 0, 1, 1);
        drive(0,0,0,0,0, 8'h00, 8'h00); cyc();
        chk_out("exp_after", 8'h00, 8'h00, 0, 0, 1);
        drive(1,0,0,0,1, 8'h00, 8'h00); cyc();
        chk_out("exp_start_ignored", 8'h00, 8'h00, 0, 0, 1);
`endif
        drive(0,0,1,0,0, 8'h00, 8'h00); cyc();
        chk_out("exp_clear", 8'h00, 8'h00, 0, 0, 0);

        // Held-high tick gives a single decrement.
        drive(0,0,0,1,0, 8'h00, 8'h10); cyc();
        drive(1,0,0,0,0, 8'h00, 8'h00); cyc();
        drive(0,0,0,0,1, 8'h00, 8'h00);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (tif.done) dones++;
        end
        chk_out("held_tick", 8'h00, 8'h09, 1, 0, 0);
        chk("held_tick_dones", 19'(dones), 19'd0);
        drive(0,0,1,0,0, 8'h00, 8'h00); cyc();

        // Asynchronous reset mid-run at 03:17.
        drive(0,0,0,1,0, 8'h03, 8'h17); cyc();
        chk_out("load_0317", 8'h03, 8'h17, 0, 0, 0);
        drive(1,0,0,0,0, 8'h00, 8'h00); cyc();
        chk_out("run_0317", 8'h03, 8'h17, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 8'h00, 0, 0, 0);
        cyc();
        cyc();
        chk_out("reset_held", 8'h00, 8'h00, 0, 0, 0);
        drive(0,0,0,0,0, 8'h00, 8'h00);
        rst_n = 1'b1;
        cyc();
        chk_out("reset_release", 8'h00, 8'h00, 0, 0, 0);

        // Reduced minute limit on the second instance.
        tif2.load = 1'b1; tif2.load_min = 8'h99; tif2.load_sec = 8'h45; cyc();
        chk("max30_clamp", {tif2.min_bcd, tif2.sec_bcd, 3'b000}, {8'h30, 8'h45, 3'b000});
        tif2.load_min = 8'h29; tif2.load_sec = 8'h6F; cyc();
        chk("max30_pass", {tif2.min_bcd, tif2.sec_bcd, 3'b000}, {8'h29, 8'h59, 3'b000});
        tif2.load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
